// File: rtl/bw_mul_arb_pkg.sv
// -----------------------------------------------------------------------------
// bw_mul_arb_pkg
// Shared types and constants for the Baugh-Wooley multiplier arbiter.
//   - occ_e        : pipeline occupancy (EMPTY / ONE / FULL), for checkers and debug
//   - s1_payload_t : operand-register payload (a, b, sign flags, requester id)
//   - id_width()   : requester index width helper
// The payload struct is sized by bw_width_lp / bw_num_req_lp; the top-level
// parameter defaults track these, so widen both together.
// Optional feature macro: BW_MUL_ARB_FIXED_PRIO_EN (handled in bw_rr_arbiter).
// -----------------------------------------------------------------------------
package bw_mul_arb_pkg;

    localparam int unsigned bw_width_lp   = 32'd4;
    localparam int unsigned bw_num_req_lp = 32'd4;

    // Index width for n requesters, never below one bit.
    function automatic int unsigned id_width(input int unsigned n);
        int unsigned w;
        if (n > 32'd1) begin
            w = $clog2(n);
        end else begin
            w = 32'd1;
        end
        return w;
    endfunction

    localparam int unsigned bw_id_w_lp = id_width(bw_num_req_lp);

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

    typedef struct packed {
        logic [bw_width_lp-1:0] a;
        logic [bw_width_lp-1:0] b;
        logic                   a_signed;
        logic                   b_signed;
        logic [bw_id_w_lp-1:0]  id;
    } s1_payload_t;

    // Occupancy of the two-stage pipeline from its valid bits.
    function automatic occ_e occupancy(input logic s1_v, input logic s2_v);
        occ_e o;
        case ({s1_v, s2_v})
            2'b00:   o = OCC_EMPTY;
            2'b11:   o = OCC_FULL;
            default: o = OCC_ONE;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/bw_mul_core.sv
// -----------------------------------------------------------------------------
// bw_mul_core
// Combinational Baugh-Wooley style multiplier. Each operand is extended to
// width_p+1 bits (top bit = signed & MSB) and the low 2*width_p bits of the
// product are returned.
// Ports: a_i, b_i (width_p), a_signed_i, b_signed_i (1), p_o (2*width_p).
// -----------------------------------------------------------------------------
module bw_mul_core #(
    parameter int unsigned width_p = 32'd4
) (
    input  logic [width_p-1:0]   a_i,
    input  logic [width_p-1:0]   b_i,
    input  logic                 a_signed_i,
    input  logic                 b_signed_i,
    output logic [2*width_p-1:0] p_o
);

    logic [width_p:0]     a_ext_s;
    logic [width_p:0]     b_ext_s;
    logic [2*width_p-1:0] a_wide_s;
    logic [2*width_p-1:0] b_wide_s;

    assign a_ext_s = {a_signed_i & a_i[width_p-1], a_i};
    assign b_ext_s = {b_signed_i & b_i[width_p-1], b_i};

    // Sign-extending to the product width makes a plain modulo-2^(2w)
    // multiply produce exactly the truncated signed (w+1)x(w+1) result.
    assign a_wide_s = {{(width_p-1){a_ext_s[width_p]}}, a_ext_s};
    assign b_wide_s = {{(width_p-1){b_ext_s[width_p]}}, b_ext_s};
    assign p_o      = a_wide_s * b_wide_s;

endmodule

// File: rtl/bw_rr_arbiter.sv
// -----------------------------------------------------------------------------
// bw_rr_arbiter
// Grants the first asserted request searching upward from ptr_i with wrap.
// Ports: req_i (num_req_p), ptr_i (id_w), en_i (1) in;
//        gnt_o (num_req_p, one-hot, zero when en_i low), idx_o (id_w) out.
// Macro BW_MUL_ARB_FIXED_PRIO_EN: search always starts at index 0
// (ptr_i is ignored).
// -----------------------------------------------------------------------------
module bw_rr_arbiter #(
    parameter int unsigned num_req_p = 32'd4,
    parameter int unsigned id_w      = 32'd2
) (
    input  logic [num_req_p-1:0] req_i,
    input  logic [id_w-1:0]      ptr_i,
    input  logic                 en_i,
    output logic [num_req_p-1:0] gnt_o,
    output logic [id_w-1:0]      idx_o
);

    logic found_s;
    int   cand_s;

    // Priority search from the start index, first hit wins.
    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        found_s = 1'b0;
        cand_s  = 0;
        for (int i = 0; i < int'(num_req_p); i++) begin
`ifdef BW_MUL_ARB_FIXED_PRIO_EN
            cand_s = i;
`else
            cand_s = int'(ptr_i) + i;
            if (cand_s >= int'(num_req_p)) begin
                cand_s = cand_s - int'(num_req_p);
            end else begin
                cand_s = cand_s;
            end
`endif
            if (!found_s && req_i[cand_s]) begin
                found_s = 1'b1;
                idx_o   = id_w'(cand_s);
            end else begin
                found_s = found_s;
            end
        end
        if (found_s && en_i) begin
            gnt_o[idx_o] = 1'b1;
        end else begin
            gnt_o = '0;
        end
    end

endmodule

// File: rtl/bw_mul_arbiter.sv
// -----------------------------------------------------------------------------
// bw_mul_arbiter
// Shares one Baugh-Wooley multiplier among num_req_p requesters through a
// two-stage pipeline: S1 registers the granted operands, S2 registers the
// product. Response is a single valid/ready port tagged with requester id.
// Ports: clk_i, rst_ni (async active-low);
//        req_valid_i/req_ready_o, req_a_i/req_b_i (packed per requester),
//        req_a_signed_i/req_b_signed_i;
//        rsp_valid_o, rsp_ready_i, rsp_p_o (2*width_p), rsp_id_o (id_w).
// Macro BW_MUL_ARB_FIXED_PRIO_EN: lowest valid index always wins, no
// round-robin pointer.
// -----------------------------------------------------------------------------
module bw_mul_arbiter
    import bw_mul_arb_pkg::*;
#(
    parameter int unsigned width_p   = bw_width_lp,
    parameter int unsigned num_req_p = bw_num_req_lp,
    localparam int unsigned id_w     = $clog2(num_req_p)
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [num_req_p-1:0]         req_valid_i,
    output logic [num_req_p-1:0]         req_ready_o,
    input  logic [num_req_p*width_p-1:0] req_a_i,
    input  logic [num_req_p*width_p-1:0] req_b_i,
    input  logic [num_req_p-1:0]         req_a_signed_i,
    input  logic [num_req_p-1:0]         req_b_signed_i,
    output logic                         rsp_valid_o,
    input  logic                         rsp_ready_i,
    output logic [2*width_p-1:0]         rsp_p_o,
    output logic [id_w-1:0]              rsp_id_o
);

    s1_payload_t          s1_q, s1_d;
    logic                 s1_v_q, s1_v_d;
    logic                 s2_v_q, s2_v_d;
    logic [2*width_p-1:0] s2_p_q, s2_p_d;
    logic [id_w-1:0]      s2_id_q, s2_id_d;
    logic [id_w-1:0]      rr_ptr_q, rr_ptr_d;
    logic [2*width_p-1:0] mul_p_s;
    logic [num_req_p-1:0] gnt_s;
    logic [id_w-1:0]      gnt_idx_s;
    logic                 s2_load_s;
    logic                 s1_accept_s;
    logic                 transfer_s;

    assign s2_load_s   = s1_v_q & (~s2_v_q | rsp_ready_i);
    assign s1_accept_s = ~s1_v_q | s2_load_s;
    // Grant already implies valid, so any ready bit means a transfer.
    assign req_ready_o = rst_ni ? gnt_s : '0;
    assign transfer_s  = |req_ready_o;

    bw_rr_arbiter #(
        .num_req_p (num_req_p),
        .id_w      (id_w)
    ) u_arb (
        .req_i (req_valid_i),
        .ptr_i (rr_ptr_q),
        .en_i  (s1_accept_s),
        .gnt_o (gnt_s),
        .idx_o (gnt_idx_s)
    );

    bw_mul_core #(
        .width_p (width_p)
    ) u_mul (
        .a_i        (s1_q.a),
        .b_i        (s1_q.b),
        .a_signed_i (s1_q.a_signed),
        .b_signed_i (s1_q.b_signed),
        .p_o        (mul_p_s)
    );

    // Next-state for both pipeline stages and the round-robin pointer.
    always_comb begin
        s1_d     = s1_q;
        s1_v_d   = s1_v_q;
        s2_p_d   = s2_p_q;
        s2_id_d  = s2_id_q;
        s2_v_d   = s2_v_q;
        rr_ptr_d = rr_ptr_q;

        if (transfer_s) begin
            s1_d.a        = req_a_i[gnt_idx_s*width_p +: width_p];
            s1_d.b        = req_b_i[gnt_idx_s*width_p +: width_p];
            s1_d.a_signed = req_a_signed_i[gnt_idx_s];
            s1_d.b_signed = req_b_signed_i[gnt_idx_s];
            s1_d.id       = gnt_idx_s;
            s1_v_d        = 1'b1;
        end else if (s2_load_s) begin
            s1_v_d = 1'b0;
        end else begin
            s1_v_d = s1_v_q;
        end

        if (s2_load_s) begin
            s2_p_d  = mul_p_s;
            s2_id_d = s1_q.id;
            s2_v_d  = 1'b1;
        end else if (rsp_ready_i) begin
            s2_v_d = 1'b0;
        end else begin
            s2_v_d = s2_v_q;
        end

`ifdef BW_MUL_ARB_FIXED_PRIO_EN
        rr_ptr_d = '0;
`else
        if (transfer_s) begin
            if (gnt_idx_s == id_w'(num_req_p - 32'd1)) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = gnt_idx_s + id_w'(1);
            end
        end else begin
            rr_ptr_d = rr_ptr_q;
        end
`endif
    end

    // Pipeline and pointer registers; reset discards all in-flight work.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_q     <= '0;
            s1_v_q   <= 1'b0;
            s2_p_q   <= '0;
            s2_id_q  <= '0;
            s2_v_q   <= 1'b0;
            rr_ptr_q <= '0;
        end else begin
            s1_q     <= s1_d;
            s1_v_q   <= s1_v_d;
            s2_p_q   <= s2_p_d;
            s2_id_q  <= s2_id_d;
            s2_v_q   <= s2_v_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign rsp_valid_o = s2_v_q;
    assign rsp_p_o     = s2_p_q;
    assign rsp_id_o    = s2_id_q;

endmodule

// File: tb/tb_bw_mul_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bw_mul_arbiter
// Self-checking bench for bw_mul_arbiter: directed vector table, round-robin
// order, backpressure, mid-operation reset and an exhaustive 4-bit sweep,
// with a scoreboard queue fed at every accepted request.
// -----------------------------------------------------------------------------
module tb_bw_mul_arbiter;

    localparam int W   = 4;
    localparam int N   = 4;
    localparam int IDW = 2;

    logic             clk = 1'b0;
    logic             rst_ni;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [N*W-1:0]   req_a;
    logic [N*W-1:0]   req_b;
    logic [N-1:0]     a_sg;
    logic [N-1:0]     b_sg;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [2*W-1:0]   rsp_p;
    logic [IDW-1:0]   rsp_id;

    int n_checks = 0;
    int n_fail   = 0;
    bit sweep_rand = 1'b0;

    typedef struct {
        logic [7:0] p;
        logic [1:0] id;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        int         r;
        logic [3:0] a;
        logic [3:0] b;
        logic       as;
        logic       bs;
        logic [7:0] p;
    } vec_t;

    always #5 clk = ~clk;

    bw_mul_arbiter dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .req_a_i        (req_a),
        .req_b_i        (req_b),
        .req_a_signed_i (a_sg),
        .req_b_signed_i (b_sg),
        .rsp_valid_o    (rsp_valid),
        .rsp_ready_i    (rsp_ready),
        .rsp_p_o        (rsp_p),
        .rsp_id_o       (rsp_id)
    );

    function automatic logic [7:0] model(input logic [3:0] a, input logic [3:0] b,
                                         input logic as, input logic bs);
        int ai, bi;
        logic [31:0] pv;
        ai = as ? int'($signed(a)) : int'(a);
        bi = bs ? int'($signed(b)) : int'(b);
        pv = ai * bi;
        return pv[7:0];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Raise valid for requester r, wait for the handshake, then drop valid.
    task automatic send(input int r, input logic [3:0] a, input logic [3:0] b,
                        input logic as, input logic bs);
        int n;
        tick();
        req_a[r*W +: W] = a;
        req_b[r*W +: W] = b;
        a_sg[r]         = as;
        b_sg[r]         = bs;
        req_valid[r]    = 1'b1;
        n = 0;
        @(negedge clk);
        while (!req_ready[r] && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("send_ready", 32'(req_ready[r]), 32'd1);
        tick();
        req_valid[r] = 1'b0;
    endtask

    // Scoreboard: push on accepted request, pop on accepted response.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_ni) begin
            sb.delete();
        end else begin
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    e.p  = model(req_a[i*W +: W], req_b[i*W +: W], a_sg[i], b_sg[i]);
                    e.id = 2'(i);
                    sb.push_back(e);
                end
            end
            if (rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    check("sb_unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("sb_p", 32'(rsp_p), 32'(e.p));
                    check("sb_id", 32'(rsp_id), 32'(e.id));
                end
            end
        end
    end

    always @(posedge clk) begin
        if (sweep_rand) begin
            #2;
            rsp_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[8];
        logic [3:0]  oh;
        int          cnt;
        bit          held;
        logic [7:0]  hold_p;
        logic [1:0]  hold_id;
        bit          t;

        vecs[0] = '{0, 4'h8, 4'h8, 1'b1, 1'b1, 8'h40};
        vecs[1] = '{2, 4'hF, 4'hF, 1'b0, 1'b0, 8'hE1};
        vecs[2] = '{2, 4'hF, 4'hF, 1'b1, 1'b0, 8'hF1};
        vecs[3] = '{1, 4'hF, 4'hF, 1'b1, 1'b1, 8'h01};
        vecs[4] = '{3, 4'h7, 4'h8, 1'b1, 1'b1, 8'hC8};
        vecs[5] = '{1, 4'h8, 4'hF, 1'b0, 1'b1, 8'hF8};
        vecs[6] = '{3, 4'h0, 4'hF, 1'b1, 1'b1, 8'h00};
        vecs[7] = '{0, 4'h7, 4'h7, 1'b1, 1'b1, 8'h31};

        rst_ni    = 1'b0;
        req_valid = 4'hF;
        req_a     = '0;
        req_b     = '0;
        a_sg      = '0;
        b_sg      = '0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_p", 32'(rsp_p), 32'd0);
        check("rst_rsp_id", 32'(rsp_id), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        req_valid = '0;
        tick();
        rst_ni = 1'b1;

        // Round-robin: all requesters valid continuously.
        tick();
        for (int i = 0; i < N; i++) begin
            req_a[i*W +: W] = 4'(i + 1);
            req_b[i*W +: W] = 4'(i + 5);
        end
        req_valid = 4'hF;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
`ifdef BW_MUL_ARB_FIXED_PRIO_EN
            oh = 4'b0001;
`else
            oh = 4'b0001 << (k % 4);
`endif
            check("rr_grant", 32'(req_ready), 32'(oh));
        end
        tick();
        req_valid = '0;
        repeat (4) tick();
        check("rr_drained", 32'(sb.size()), 32'd0);

        // Directed vectors with 2-edge latency.
        for (int v = 0; v < 8; v++) begin
            send(vecs[v].r, vecs[v].a, vecs[v].b, vecs[v].as, vecs[v].bs);
            @(negedge clk);
            check("vec_not_early", 32'(rsp_valid), 32'd0);
            @(negedge clk);
            check("vec_valid", 32'(rsp_valid), 32'd1);
            check("vec_p", 32'(rsp_p), 32'(vecs[v].p));
            check("vec_id", 32'(rsp_id), 32'(vecs[v].r));
        end
        repeat (2) tick();

        // Backpressure: req1 streams while the response port is stalled.
        rsp_ready        = 1'b0;
        req_a[1*W +: W]  = 4'h1;
        req_b[1*W +: W]  = 4'h3;
        a_sg[1]          = 1'b0;
        b_sg[1]          = 1'b0;
        req_valid[1]     = 1'b1;
        cnt  = 0;
        held = 1'b0;
        hold_p  = '0;
        hold_id = '0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            t = req_valid[1] & req_ready[1];
            if (t) cnt++;
            if (rsp_valid) begin
                if (!held) begin
                    hold_p  = rsp_p;
                    hold_id = rsp_id;
                    held    = 1'b1;
                end else begin
                    check("bp_p_stable", 32'(rsp_p), 32'(hold_p));
                    check("bp_id_stable", 32'(rsp_id), 32'(hold_id));
                end
            end
            tick();
            if (t) req_a[1*W +: W] = req_a[1*W +: W] + 4'h1;
        end
        check("bp_accept_count", 32'(cnt), 32'd2);
        check("bp_ready_low", 32'(req_ready), 32'd0);
        check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (4) tick();
        check("bp_drained", 32'(sb.size()), 32'd0);

        // Reset with a full pipeline.
        rsp_ready       = 1'b0;
        req_a[0*W +: W] = 4'h2;
        req_b[0*W +: W] = 4'h2;
        a_sg[0]         = 1'b0;
        b_sg[0]         = 1'b0;
        req_valid[0]    = 1'b1;
        repeat (3) tick();
        check("full_rsp_valid", 32'(rsp_valid), 32'd1);
        #2;
        rst_ni = 1'b0;
        #1;
        check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("midrst_req_ready", 32'(req_ready), 32'd0);
        req_a[0*W +: W] = 4'h3;
        req_b[0*W +: W] = 4'h5;
        req_valid       = 4'b1001;
        tick();
        tick();
        rst_ni    = 1'b1;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("rst_rr_restart", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        @(negedge clk);
        check("rst_not_early", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        check("rst_rsp_valid_after", 32'(rsp_valid), 32'd1);
        check("rst_rsp_p_after", 32'(rsp_p), 32'h0F);
        check("rst_rsp_id_after", 32'(rsp_id), 32'd0);
        repeat (3) tick();

        // Exhaustive 4-bit sweep with random requester and random backpressure.
        sweep_rand = 1'b1;
        for (int sg = 0; sg < 4; sg++) begin
            for (int ai = 0; ai < 16; ai++) begin
                for (int bi = 0; bi < 16; bi++) begin
                    send(int'($urandom_range(0, 3)), 4'(ai), 4'(bi), sg[0], sg[1]);
                end
            end
        end
        sweep_rand = 1'b0;
        repeat (2) tick();
        rsp_ready = 1'b1;
        repeat (6) tick();
        check("sweep_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
